score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_ctrl.sv | 141 ++++++++++++++
 tb/tb_score_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// Score controller: run/pause/stop FSM, divided tick prescaler, 4-digit BCD
// score with saturation at 9999, and a frame-latched copy for the digit ROMs.
module score_ctrl #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        frame_start,
  output logic [15:0] bcd_live,
  output logic [15:0] bcd_disp,
  output logic [1:0]  state,
  output logic        tick,
  output logic        maxed
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic [PW-1:0] prescaler;
  logic          restart;   // clear score, prescaler and maxed this edge
  logic          advance;   // staying in RUN with no control pulse: prescaler moves
  logic          due;       // prescaler wraps this edge
  logic          hit_max;   // increment requested while already at 9999
  logic          inc;       // score actually increments this edge

  // Decimal increment with ripple carry; digits never leave 0..9.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state decode; stop outranks pause, pause outranks start.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nxt_state = cur_state;
    restart   = 1'b0;
    advance   = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_RUN;
          restart   = 1'b1;
        end
      end
      S_RUN: begin
        if (stop)       nxt_state = S_DONE;
        else if (pause) nxt_state = S_PAUSE;
        else if (start) restart   = 1'b1;
        else            advance   = 1'b1;
      end
      S_PAUSE: begin
        if (stop)       nxt_state = S_DONE;
        else if (pause) nxt_state = S_RUN;
        else if (start) begin
          nxt_state = S_RUN;
          restart   = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          nxt_state = S_RUN;
          restart   = 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    due     = advance && (prescaler == PRE_LAST);
    hit_max = due && (bcd_live == 16'h9999);
    inc     = due && !hit_max;
    if (hit_max) nxt_state = S_DONE;
  end

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Prescaler: counts only while running undisturbed, holds otherwise.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)        prescaler <= '0;
    else if (restart) prescaler <= '0;
    else if (advance) prescaler <= due ? '0 : prescaler + 1'b1;
  end

  // Live score, sticky saturation flag and the one-cycle increment pulse.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      bcd_live <= 16'h0000;
      maxed    <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= inc;
      if (restart) begin
        bcd_live <= 16'h0000;
        maxed    <= 1'b0;
      end else begin
        if (inc)     bcd_live <= bcd_inc(bcd_live);
        if (hit_max) maxed    <= 1'b1;
      end
    end
  end

  // Display copy: loads the pre-edge live score on each frame pulse.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)            bcd_disp <= 16'h0000;
    else if (frame_start) bcd_disp <= bcd_live;
  end

  assign state = cur_state;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with TICK_DIV=4. Expected scores are pushed
// to a scoreboard queue as runs are launched and popped on every tick.
module tb_score_ctrl;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] bcd_live;
  logic [15:0] bcd_disp;
  logic [1:0]  state;
  logic        tick;
  logic        maxed;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [15:0] exp_q[$];
  int unsigned tick_times[$];
  logic [15:0] mon_exp;
  logic [15:0] prev_disp;
  int unsigned resume_cyc;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_DONE = 2'b11;

  score_ctrl #(.TICK_DIV(4)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .frame_start (frame_start),
    .bcd_live    (bcd_live),
    .bcd_disp    (bcd_disp),
    .state       (state),
    .tick        (tick),
    .maxed       (maxed)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Hold the given pulses across exactly one rising edge.
  task automatic pulse(input logic s, input logic p, input logic t, input logic f);
    start = s; pause = p; stop = t; frame_start = f;
    step(1);
    start = 1'b0; pause = 1'b0; stop = 1'b0; frame_start = 1'b0;
  endtask

  // Scoreboard consumer: every tick must match the next expected score.
  // A pulse at the saturation edge (maxed just set, nothing queued) is tolerated.
  always @(negedge sys_clk) begin
    if (tick === 1'b1) begin
      tick_times.push_back(cyc);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("tick_score", 32'(bcd_live), 32'(mon_exp));
      end else if (maxed !== 1'b1) begin
        check("unexpected_tick", 32'(tick), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_live", 32'(bcd_live), 32'h0);
    check("rst_disp", 32'(bcd_disp), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_maxed", 32'(maxed), 32'h0);
    step(2);
    reset = 1'b0;

    // IDLE ignores pause and stop.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_ignore", 32'(state), 32'(ST_IDLE));

    // 40 cycles of RUN: ten ticks, four cycles apart.
    for (int i = 1; i <= 10; i++) exp_q.push_back(to_bcd(i));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick_times.delete();
    check("run_entry_state", 32'(state), 32'(ST_RUN));
    check("run_entry_live", 32'(bcd_live), 32'h0);
    step(40);
    check("run40_live", 32'(bcd_live), 32'h0010);
    check("run40_tick", 32'(tick), 32'h1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("stop_state", 32'(state), 32'(ST_DONE));
    check("tick_one_cycle", 32'(tick), 32'h0);
    check("tick_count", 32'(tick_times.size()), 32'd10);
    for (int i = 1; i < tick_times.size(); i++)
      check("tick_spacing", tick_times[i] - tick_times[i-1], 32'd4);

    // Pause after two prescaler counts, long pause, resume: tick 2 cycles later.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_state", 32'(state), 32'(ST_PAUSE));
    step(100);
    check("pause_hold_live", 32'(bcd_live), 32'h0);
    exp_q.push_back(to_bcd(1));
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    resume_cyc = cyc;
    check("resume_state", 32'(state), 32'(ST_RUN));
    step(1);
    check("resume_no_tick_yet", 32'(tick), 32'h0);
    step(1);
    check("resume_tick", 32'(tick), 32'h1);
    check("resume_tick_cycle", cyc - resume_cyc, 32'd2);
    check("resume_live", 32'(bcd_live), 32'h0001);

    // Pause on the edge a tick is due: no increment until after resume.
    step(3);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_due_live", 32'(bcd_live), 32'h0001);
    check("pause_due_tick", 32'(tick), 32'h0);
    step(5);
    exp_q.push_back(to_bcd(2));
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    check("resume_due_live", 32'(bcd_live), 32'h0002);
    check("resume_due_tick", 32'(tick), 32'h1);

    // Stop on the edge a tick is due: stop wins.
    step(3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("stop_due_state", 32'(state), 32'(ST_DONE));
    check("stop_due_live", 32'(bcd_live), 32'h0002);
    check("stop_due_tick", 32'(tick), 32'h0);

    // Restart while running; pause outranks start; stop from PAUSE.
    exp_q.push_back(to_bcd(1));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(6);
    check("pre_restart_live", 32'(bcd_live), 32'h0001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_state", 32'(state), 32'(ST_RUN));
    check("restart_live", 32'(bcd_live), 32'h0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("pause_over_start", 32'(state), 32'(ST_PAUSE));
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_stop_state", 32'(state), 32'(ST_DONE));

    // Full count: 0999 -> 1000 carry, then saturation at 9999.
    for (int i = 1; i <= 9999; i++) exp_q.push_back(to_bcd(i));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(3996);
    check("live_0999", 32'(bcd_live), 32'h0999);
    step(4);
    check("live_1000", 32'(bcd_live), 32'h1000);
    step(39996 - 4000);
    check("live_9999", 32'(bcd_live), 32'h9999);
    check("pre_max_maxed", 32'(maxed), 32'h0);
    check("pre_max_state", 32'(state), 32'(ST_RUN));
    step(4);
    check("sat_live", 32'(bcd_live), 32'h9999);
    check("sat_maxed", 32'(maxed), 32'h1);
    check("sat_state", 32'(state), 32'(ST_DONE));
    step(20);
    check("sat_no_ticks", 32'(exp_q.size()), 32'd0);
    check("sat_hold_live", 32'(bcd_live), 32'h9999);

    // Frame latch works in DONE.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("disp_done", 32'(bcd_disp), 32'h9999);
    prev_disp = 16'h9999;

    // Restart clears maxed; stop+pause together in RUN go to DONE.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_maxed", 32'(maxed), 32'h0);
    check("restart_live2", 32'(bcd_live), 32'h0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("stop_pause_state", 32'(state), 32'(ST_DONE));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_after_sp_state", 32'(state), 32'(ST_RUN));
    check("start_after_sp_live", 32'(bcd_live), 32'h0);
    check("start_after_sp_maxed", 32'(maxed), 32'h0);

    // frame_start every 17 cycles; display holds between frames and takes the
    // pre-edge score (edge 68 coincides with an increment).
    for (int i = 1; i <= 25; i++) exp_q.push_back(to_bcd(i));
    for (int k = 1; k <= 6; k++) begin
      step(16);
      check("disp_hold", 32'(bcd_disp), 32'(prev_disp));
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      prev_disp = to_bcd((17 * k - 1) / 4);
      check("disp_frame", 32'(bcd_disp), 32'(prev_disp));
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("frame_run_stop", 32'(state), 32'(ST_DONE));

    // Asynchronous reset mid-run at 0123.
    for (int i = 1; i <= 123; i++) exp_q.push_back(to_bcd(i));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(493);
    check("pre_reset_live", 32'(bcd_live), 32'h0123);
    #2 reset = 1'b1;
    #1;
    check("async_state", 32'(state), 32'(ST_IDLE));
    check("async_live", 32'(bcd_live), 32'h0);
    check("async_disp", 32'(bcd_disp), 32'h0);
    check("async_tick", 32'(tick), 32'h0);
    check("async_maxed", 32'(maxed), 32'h0);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("start_in_reset", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;
    exp_q.push_back(to_bcd(1));
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_state", 32'(state), 32'(ST_RUN));
    check("post_reset_live", 32'(bcd_live), 32'h0);
    step(4);
    check("post_reset_count", 32'(bcd_live), 32'h0001);
    step(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
